// File: rtl/gcbp_match_sched_pkg.sv
// Shared GCBP parameters: sub-image geometry, read FSM encoding, read tag and BRAM address helper.
// Pure declarations, no logic.
package gcbp_match_sched_pkg;

  localparam int C_SUBIMAGE_H     = 64;
  localparam int C_SLOT_LINE_BITS = 7;
  localparam int C_ADDR_BITS      = 9;
  localparam int C_LOC_BITS       = C_ADDR_BITS - C_SLOT_LINE_BITS;
  localparam int C_LINE_BITS      = $clog2(C_SUBIMAGE_H);

  localparam logic [C_LINE_BITS-1:0] C_LAST_LINE = C_LINE_BITS'(C_SUBIMAGE_H - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_CURR = 2'd1,
    S_RD_PREV = 2'd2,
    S_DRAIN   = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic                   rd_en;
    logic                   is_prev;
    logic [C_LINE_BITS-1:0] idx;
  } rd_tag_t;

  // Shared with the write-side decoder: a slot occupies one 2^C_SLOT_LINE_BITS address window.
  function automatic logic [C_ADDR_BITS-1:0] bram_addr(input logic [C_LOC_BITS-1:0]       loc,
                                                       input logic [C_SLOT_LINE_BITS-1:0] line);
    return {loc, line};
  endfunction

endpackage

// File: rtl/gcbp_match_sched_if.sv
// Frame-done/slot inputs, match-engine ready, BRAM port-B read controls and tagged line outputs.
// master = scheduler side, slave = surrounding GCBP logic and matching engine.
interface gcbp_match_sched_if;
  import gcbp_match_sched_pkg::*;

  logic                   i_frame_done;
  logic [C_LOC_BITS-1:0]  i_curr_frame_loc;
  logic [C_LOC_BITS-1:0]  i_prev_frame_loc;
  logic                   i_match_ready;
  logic [C_ADDR_BITS-1:0] o_bram_rd_addr;
  logic                   o_bram_rd_en;
  logic                   o_line_valid;
  logic                   o_line_is_prev;
  logic [C_LINE_BITS-1:0] o_line_idx;
  logic                   o_busy;
  logic                   o_match_done;
  logic                   o_overrun;

  modport master (
    input  i_frame_done, i_curr_frame_loc, i_prev_frame_loc, i_match_ready,
    output o_bram_rd_addr, o_bram_rd_en, o_line_valid, o_line_is_prev, o_line_idx,
           o_busy, o_match_done, o_overrun
  );

  modport slave (
    output i_frame_done, i_curr_frame_loc, i_prev_frame_loc, i_match_ready,
    input  o_bram_rd_addr, o_bram_rd_en, o_line_valid, o_line_is_prev, o_line_idx,
           o_busy, o_match_done, o_overrun
  );

endinterface

// File: rtl/gcbp_match_sched_rd_tag_pipe.sv
// Delays the read tag {rd_en, is_prev, idx} by one cycle to line up with 1-cycle BRAM read data.
// Latency 1; no backpressure, every issued read returns.
module gcbp_rd_tag_pipe
  import gcbp_match_sched_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_resetn,
  input  rd_tag_t tag_d,
  output rd_tag_t tag_q
);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) tag_q <= '0;
    else           tag_q <= tag_d;
  end

endmodule

// File: rtl/gcbp_match_sched.sv
// Alternating curr/prev port-B reads, 64 lines per frame pass, tagged for the matching engine.
// Read data valid 1 cycle after issue; i_match_ready gates issue only, the in-flight read still returns.
module gcbp_match_sched
  import gcbp_match_sched_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_resetn,
  gcbp_match_sched_if.master bus
);

  sched_state_t           state, state_nxt;
  logic                   r_have_prev;
  logic [C_LOC_BITS-1:0]  r_curr_loc;
  logic [C_LOC_BITS-1:0]  r_prev_loc;
  logic [C_LINE_BITS-1:0] r_line;
  logic                   r_match_done;
  logic                   r_overrun;

  logic                   rd_en;
  logic [C_ADDR_BITS-1:0] rd_addr;
  logic                   busy;
  logic                   last_line;
  rd_tag_t                tag_d;
  rd_tag_t                tag_q;

  assign last_line = (r_line == C_LAST_LINE);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.i_frame_done && r_have_prev) state_nxt = S_RD_CURR;
      S_RD_CURR: if (bus.i_match_ready) state_nxt = S_RD_PREV;
      S_RD_PREV: if (bus.i_match_ready) state_nxt = last_line ? S_DRAIN : S_RD_CURR;
      S_DRAIN:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // The very first frame after reset has no predecessor to match against, so it only arms r_have_prev.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_have_prev  <= 1'b0;
      r_curr_loc   <= '0;
      r_prev_loc   <= '0;
      r_line       <= '0;
      r_match_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_match_done <= (state == S_DRAIN);
      if (bus.i_frame_done && (state != S_IDLE)) r_overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.i_frame_done) begin
            if (r_have_prev) begin
              r_curr_loc <= bus.i_curr_frame_loc;
              r_prev_loc <= bus.i_prev_frame_loc;
              r_line     <= '0;
            end else begin
              r_have_prev <= 1'b1;
            end
          end
        end
        S_RD_PREV: if (bus.i_match_ready && !last_line) r_line <= r_line + C_LINE_BITS'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    tag_d   = '0;
    busy    = (state != S_IDLE);
    case (state)
      S_RD_CURR: begin
        rd_addr = bram_addr(r_curr_loc, C_SLOT_LINE_BITS'(r_line));
        rd_en   = bus.i_match_ready;
      end
      S_RD_PREV: begin
        rd_addr = bram_addr(r_prev_loc, C_SLOT_LINE_BITS'(r_line));
        rd_en   = bus.i_match_ready;
      end
      default: ;
    endcase
    tag_d.rd_en   = rd_en;
    tag_d.is_prev = rd_en && (state == S_RD_PREV);
    tag_d.idx     = rd_en ? r_line : '0;
  end

  gcbp_rd_tag_pipe u_tag_pipe (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .tag_d    (tag_d),
    .tag_q    (tag_q)
  );

  assign bus.o_bram_rd_addr = rd_addr;
  assign bus.o_bram_rd_en   = rd_en;
  assign bus.o_line_valid   = tag_q.rd_en;
  assign bus.o_line_is_prev = tag_q.is_prev;
  assign bus.o_line_idx     = tag_q.idx;
  assign bus.o_busy         = busy;
  assign bus.o_match_done   = r_match_done;
  assign bus.o_overrun      = r_overrun;

endmodule

// File: tb/tb_gcbp_match_sched.sv
// Directed + randomized bench for gcbp_match_sched against a queue-based pass model.
module tb_gcbp_match_sched;
  import gcbp_match_sched_pkg::*;

  logic i_clk    = 1'b0;
  logic i_resetn = 1'b0;
  always #5 i_clk = ~i_clk;

  gcbp_match_sched_if bus ();

  gcbp_match_sched dut (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit prev;
    int line;
  } rd_t;

  // Reference model: a pass is the list of reads still owed, in order.
  rd_t m_q[$];
  rd_t m_last;
  int  m_cloc, m_ploc;
  bit  m_busy, m_have_prev, m_overrun, m_drain, m_done, m_lv;
  bit  chk_on  = 1'b0;
  int  n_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy = 0; m_have_prev = 0; m_overrun = 0; m_drain = 0; m_done = 0; m_lv = 0;
    m_cloc = 0; m_ploc = 0;
  endtask

  // One clock: inputs already driven, sample at negedge, advance model, return just after posedge.
  task automatic cyc();
    rd_t e;
    bit  exp_rd, cur_busy, was_drain, fd;
    int  exp_addr;
    @(negedge i_clk);
    exp_rd = (m_q.size() > 0) && (bus.i_match_ready === 1'b1);
    if (chk_on) begin
      chk("rd_en", 32'(bus.o_bram_rd_en), 32'(exp_rd));
      if (exp_rd) begin
        e = m_q[0];
        exp_addr = (e.prev ? m_ploc : m_cloc) * 128 + e.line;
        chk("rd_addr", 32'(bus.o_bram_rd_addr), 32'(exp_addr));
      end
      chk("line_valid", 32'(bus.o_line_valid), 32'(m_lv));
      if (m_lv) begin
        chk("line_is_prev", 32'(bus.o_line_is_prev), 32'(m_last.prev));
        chk("line_idx", 32'(bus.o_line_idx), 32'(m_last.line));
      end
      chk("busy", 32'(bus.o_busy), 32'(m_busy));
      chk("match_done", 32'(bus.o_match_done), 32'(m_done));
      chk("overrun", 32'(bus.o_overrun), 32'(m_overrun));
    end
    if (bus.o_line_valid === 1'b1) n_valid++;

    if (!i_resetn) begin
      model_clear();
    end else begin
      cur_busy  = m_busy;
      was_drain = m_drain;
      fd        = (bus.i_frame_done === 1'b1);
      m_done    = was_drain;
      m_drain   = 0;
      if (was_drain) m_busy = 0;
      m_lv = exp_rd;
      if (exp_rd) begin
        m_last = m_q.pop_front();
        if (m_q.size() == 0) m_drain = 1;
      end
      if (fd) begin
        if (cur_busy) m_overrun = 1;
        else if (m_have_prev) begin
          m_cloc = int'(bus.i_curr_frame_loc);
          m_ploc = int'(bus.i_prev_frame_loc);
          for (int l = 0; l < C_SUBIMAGE_H; l++) begin
            m_q.push_back('{prev: 1'b0, line: l});
            m_q.push_back('{prev: 1'b1, line: l});
          end
          m_busy = 1;
        end else m_have_prev = 1;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_fd(input int cloc, input int ploc);
    bus.i_curr_frame_loc = 2'(cloc);
    bus.i_prev_frame_loc = 2'(ploc);
    bus.i_frame_done     = 1'b1;
    cyc();
    bus.i_frame_done     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Runs while the model has a pass in progress; randomized ready when rnd is set.
  task automatic run_pass(input bit rnd, input string tag);
    int n = 0;
    while (m_busy && n < 3000) begin
      bus.i_match_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc();
      n++;
    end
    bus.i_match_ready = 1'b1;
    chk(tag, 32'(bus.o_busy), 32'(0));
  endtask

  task automatic run_reads(input int k);
    int n = 0;
    while ((m_q.size() > 2 * C_SUBIMAGE_H - k) && n < 3000) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int trail;
    model_clear();
    bus.i_frame_done     = 1'b0;
    bus.i_curr_frame_loc = '0;
    bus.i_prev_frame_loc = '0;
    bus.i_match_ready    = 1'b0;

    // Reset
    @(posedge i_clk);
    #1;
    chk_on = 1'b1;
    idle_cycles(3);
    chk("rst_addr", 32'(bus.o_bram_rd_addr), 32'(0));
    chk("rst_idx", 32'(bus.o_line_idx), 32'(0));
    i_resetn = 1'b1;
    bus.i_match_ready = 1'b1;
    idle_cycles(2);

    // First frame only arms; second starts a pass on slots curr=1 prev=0
    pulse_fd(1, 0);
    idle_cycles(10);
    n_valid = 0;
    pulse_fd(1, 0);
    run_pass(1'b0, "pass1_end");
    idle_cycles(2);
    chk("pass1_valid_cnt", 32'(n_valid), 32'(128));

    // Ready dropped for 5 cycles mid-pass
    n_valid = 0;
    pulse_fd($urandom_range(0, 3), $urandom_range(0, 3));
    idle_cycles(30);
    bus.i_match_ready = 1'b0;
    trail = n_valid;
    idle_cycles(5);
    chk("trail_valid", 32'(n_valid - trail), 32'(1));
    bus.i_match_ready = 1'b1;
    run_pass(1'b0, "pass2_end");
    idle_cycles(2);
    chk("pass2_valid_cnt", 32'(n_valid), 32'(128));

    // Overrun at read 40 plus loc changes mid-pass
    pulse_fd(2, 3);
    run_reads(40);
    pulse_fd(0, 1);
    bus.i_curr_frame_loc = 2'd3;
    bus.i_prev_frame_loc = 2'd2;
    run_pass(1'b0, "pass3_end");
    idle_cycles(10);

    // Random ready, new frame accepted on the match_done cycle
    for (int p = 0; p < 3; p++) begin
      n_valid = 0;
      if (p == 0) pulse_fd($urandom_range(0, 3), $urandom_range(0, 3));
      run_pass(1'b1, "rnd_pass_end");
      pulse_fd($urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_pass(1'b1, "rnd_pass_last_end");
    idle_cycles(3);

    // Reset at read 70 aborts; next frame only re-arms
    pulse_fd(3, 1);
    run_reads(70);
    i_resetn = 1'b0;
    cyc();
    i_resetn = 1'b1;
    idle_cycles(2);
    pulse_fd(2, 0);
    idle_cycles(10);
    chk("post_rst_no_pass", 32'(bus.o_busy), 32'(0));
    n_valid = 0;
    pulse_fd(0, 2);
    run_pass(1'b1, "pass_after_rst_end");
    idle_cycles(2);
    chk("pass_after_rst_cnt", 32'(n_valid), 32'(128));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
